overload_frame_generator: RTL

//  Consumes interframe_spacing's dominant-in-intermission event and sends the CAN overload frame.

---
 rtl/can_pkg.sv | 17 +
 rtl/can_bit_counter.sv | 40 ++++
 rtl/overload_frame_generator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared types and constants for the CAN overload frame generator.
package can_pkg;

  typedef enum logic [2:0] {
    StIdle          = 3'd0,
    StFlag          = 3'd1,
    StWaitRecessive = 3'd2,
    StDelimiter     = 3'd3,
    StDone          = 3'd4
  } ovl_state_t;

  localparam logic [3:0] CAN_OVL_FLAG_BITS  = 4'd6;
  localparam logic [3:0] CAN_OVL_DELIM_BITS = 4'd8;
  localparam logic [3:0] CAN_OVL_MAX_WAIT   = 4'd7;
  localparam logic [1:0] CAN_OVL_MAX_CONSEC = 2'd2;

endpackage

// File: rtl/can_bit_counter.sv
// Bit counter with clear, load-one and saturating increment.
// o_last flags that the next increment reaches i_terminal.
module can_bit_counter (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_clear,
  input  logic       i_load_one,
  input  logic       i_inc,
  input  logic [3:0] i_terminal,
  output logic [3:0] o_count,
  output logic       o_last
);

  logic [3:0] r_count;
  logic [3:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_clear) begin
      w_count_next = 4'd0;
    end else if (i_load_one) begin
      w_count_next = 4'd1;
    end else if (i_inc && (r_count != 4'hf)) begin
      w_count_next = r_count + 4'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || !i_enable) begin
      r_count <= 4'd0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;
  assign o_last  = ((r_count + 4'd1) == i_terminal);

endmodule

// File: rtl/overload_frame_generator.sv
// CAN overload frame generator: dominant flag, wait for recessive bus, recessive delimiter.
// Checks the bus for bit/form/stuck errors and caps back-to-back overload frames.
module overload_frame_generator
  import can_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_sample_point,
  input  logic       i_rx_bit,
  input  logic       i_overload_trigger,
  input  logic       i_frame_start,
  output logic       o_tx_bit,
  output logic       o_overload_active,
  output logic       o_overload_complete,
  output logic       o_bit_error,
  output logic       o_form_error,
  output logic       o_stuck_error,
  output logic       o_overload_rejected,
  output logic [3:0] o_bit_count,
  output logic [1:0] o_consec_count
);

  ovl_state_t r_state, w_state_next;
  logic       r_tx_bit, w_tx_bit_next;
  logic       r_active, w_active_next;
  logic       r_complete, w_complete_next;
  logic       r_bit_error, w_bit_error_next;
  logic       r_form_error, w_form_error_next;
  logic       r_stuck_error, w_stuck_error_next;
  logic       r_rejected, w_rejected_next;
  logic [1:0] r_consec, w_consec_next;

  logic       w_cnt_clear;
  logic       w_cnt_load_one;
  logic       w_cnt_inc;
  logic [3:0] w_cnt_terminal;
  logic [3:0] w_cnt_value;
  logic       w_cnt_last;
  logic       w_consec_room;

  assign w_consec_room = (r_consec < CAN_OVL_MAX_CONSEC);

  can_bit_counter u_bit_counter (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_enable   (i_enable),
    .i_clear    (w_cnt_clear),
    .i_load_one (w_cnt_load_one),
    .i_inc      (w_cnt_inc),
    .i_terminal (w_cnt_terminal),
    .o_count    (w_cnt_value),
    .o_last     (w_cnt_last)
  );

  always_comb begin
    w_state_next       = r_state;
    w_tx_bit_next      = r_tx_bit;
    w_active_next      = r_active;
    w_complete_next    = 1'b0;
    w_bit_error_next   = 1'b0;
    w_form_error_next  = 1'b0;
    w_stuck_error_next = 1'b0;
    w_rejected_next    = 1'b0;
    w_consec_next      = r_consec;
    w_cnt_clear        = 1'b0;
    w_cnt_load_one     = 1'b0;
    w_cnt_inc          = 1'b0;
    w_cnt_terminal     = CAN_OVL_FLAG_BITS;

    unique case (r_state)
      StIdle: begin
        w_tx_bit_next = 1'b1;
        w_active_next = 1'b0;
        if (i_overload_trigger && !i_frame_start) begin
          if (w_consec_room) begin
            w_state_next  = StFlag;
            w_tx_bit_next = 1'b0;
            w_active_next = 1'b1;
            w_cnt_clear   = 1'b1;
            w_consec_next = r_consec + 2'd1;
          end else begin
            w_rejected_next = 1'b1;
          end
        end
      end
      StFlag: begin
        w_cnt_terminal = CAN_OVL_FLAG_BITS;
        if (i_sample_point) begin
          if (!i_rx_bit) begin
            if (w_cnt_last) begin
              w_state_next  = StWaitRecessive;
              w_tx_bit_next = 1'b1;
              w_cnt_clear   = 1'b1;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            w_bit_error_next = 1'b1;
            w_state_next     = StIdle;
            w_tx_bit_next    = 1'b1;
            w_active_next    = 1'b0;
            w_cnt_clear      = 1'b1;
          end
        end
      end
      StWaitRecessive: begin
        // Other nodes may still be sending their flags; tolerate up to MAX_WAIT dominant bits.
        w_cnt_terminal = CAN_OVL_MAX_WAIT + 4'd1;
        if (i_sample_point) begin
          if (i_rx_bit) begin
            w_state_next   = StDelimiter;
            w_cnt_load_one = 1'b1;
          end else if (w_cnt_last) begin
            w_stuck_error_next = 1'b1;
            w_state_next       = StIdle;
            w_active_next      = 1'b0;
            w_cnt_clear        = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      StDelimiter: begin
        w_cnt_terminal = CAN_OVL_DELIM_BITS;
        if (i_sample_point) begin
          if (i_rx_bit) begin
            w_cnt_inc = 1'b1;
            if (w_cnt_last) begin
              w_state_next    = StDone;
              w_active_next   = 1'b0;
              w_complete_next = 1'b1;
            end
          end else if (w_cnt_last && w_consec_room) begin
            // Dominant last delimiter bit is an overload condition of its own.
            w_state_next  = StFlag;
            w_tx_bit_next = 1'b0;
            w_cnt_clear   = 1'b1;
            w_consec_next = r_consec + 2'd1;
          end else begin
            w_form_error_next = 1'b1;
            w_state_next      = StIdle;
            w_active_next     = 1'b0;
            w_cnt_clear       = 1'b1;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_cnt_clear  = 1'b1;
      end
      default: begin
        w_state_next  = StIdle;
        w_tx_bit_next = 1'b1;
        w_active_next = 1'b0;
        w_cnt_clear   = 1'b1;
      end
    endcase

    if (i_frame_start) begin
      w_consec_next = 2'd0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || !i_enable) begin
      r_state       <= StIdle;
      r_tx_bit      <= 1'b1;
      r_active      <= 1'b0;
      r_complete    <= 1'b0;
      r_bit_error   <= 1'b0;
      r_form_error  <= 1'b0;
      r_stuck_error <= 1'b0;
      r_rejected    <= 1'b0;
      r_consec      <= 2'd0;
    end else begin
      r_state       <= w_state_next;
      r_tx_bit      <= w_tx_bit_next;
      r_active      <= w_active_next;
      r_complete    <= w_complete_next;
      r_bit_error   <= w_bit_error_next;
      r_form_error  <= w_form_error_next;
      r_stuck_error <= w_stuck_error_next;
      r_rejected    <= w_rejected_next;
      r_consec      <= w_consec_next;
    end
  end

  assign o_tx_bit            = r_tx_bit;
  assign o_overload_active   = r_active;
  assign o_overload_complete = r_complete;
  assign o_bit_error         = r_bit_error;
  assign o_form_error        = r_form_error;
  assign o_stuck_error       = r_stuck_error;
  assign o_overload_rejected = r_rejected;
  assign o_bit_count         = w_cnt_value;
  assign o_consec_count      = r_consec;

endmodule
